// File: rtl/uart_pkg.sv
// Shared constants and slot word type for the UART receive path.
// Slot width follows UART_RX_FIFO_ERR_EN (adds a framing-error bit per byte).
package uart_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned UART_OVR_CNT_W = 8;

`ifdef UART_RX_FIFO_ERR_EN
  localparam int unsigned UART_SLOT_W = UART_DATA_W + 1;
`else
  localparam int unsigned UART_SLOT_W = UART_DATA_W;
`endif

  typedef logic [UART_SLOT_W-1:0] uart_slot_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with show-ahead valid/ready read side and sticky overrun tracking.
// Define UART_RX_FIFO_ERR_EN to carry a framing-error bit with each byte (wr_err/rd_err/err_seen).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_W-1:0]    wr_data,
  input  logic                      wr_stb,
  output logic [UART_DATA_W-1:0]    rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [AW:0]               count,
  output logic                      full,
  output logic                      overrun,
  output logic [UART_OVR_CNT_W-1:0] ovr_cnt,
  input  logic                      ovr_clr
`ifdef UART_RX_FIFO_ERR_EN
  ,
  input  logic                      wr_err,
  output logic                      rd_err,
  output logic                      err_seen
`endif
);

  logic [AW:0]               wp_q, rp_q;
  logic                      overrun_q;
  logic [UART_OVR_CNT_W-1:0] ovr_cnt_q;
  logic                      empty;
  logic                      rd_fire;
  logic                      wr_acc;
  logic                      drop;
  uart_slot_t                wslot, rslot;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign rd_valid = !empty;
  assign count    = wp_q - rp_q;
  assign rd_fire  = rd_valid && rd_ready;
  // A read in the same cycle frees the slot, so a strobe while full is still accepted.
  assign wr_acc   = wr_stb && (!full || rd_fire);
  assign drop     = wr_stb && full && !rd_fire;

  assign overrun  = overrun_q;
  assign ovr_cnt  = ovr_cnt_q;

`ifdef UART_RX_FIFO_ERR_EN
  logic err_seen_q;
  assign wslot    = {wr_err, wr_data};
  assign rd_err   = rslot[UART_DATA_W];
  assign err_seen = err_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_seen_q <= 1'b0;
    end else if (wr_acc && wr_err) begin
      err_seen_q <= 1'b1;
    end else if (ovr_clr) begin
      err_seen_q <= 1'b0;
    end
  end
`else
  assign wslot = wr_data;
`endif

  assign rd_data = rslot[UART_DATA_W-1:0];

  uart_fifo_mem #(
    .Depth (DEPTH),
    .Width (UART_SLOT_W),
    .AddrW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wp_q[AW-1:0]),
    .wdata (wslot),
    .raddr (rp_q[AW-1:0]),
    .rdata (rslot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      if (wr_acc) begin
        wp_q <= wp_q + 1'b1;
      end
      if (rd_fire) begin
        rp_q <= rp_q + 1'b1;
      end
      // A drop in the same cycle as ovr_clr restarts the count at one.
      if (drop) begin
        overrun_q <= 1'b1;
        if (ovr_clr) begin
          ovr_cnt_q <= UART_OVR_CNT_W'(1);
        end else if (ovr_cnt_q != '1) begin
          ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
        ovr_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus queue scoreboard and corner sequences.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_stb = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic [7:0] ovr_cnt;
  logic       ovr_clr = 1'b0;
`ifdef UART_RX_FIFO_ERR_EN
  logic       wr_err = 1'b0;
  logic       rd_err;
  logic       err_seen;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .overrun  (overrun),
    .ovr_cnt  (ovr_cnt),
    .ovr_clr  (ovr_clr)
`ifdef UART_RX_FIFO_ERR_EN
    ,
    .wr_err   (wr_err),
    .rd_err   (rd_err),
    .err_seen (err_seen)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] sb_q[$];
  bit         m_ovr = 1'b0;
  int         m_ocnt = 0;

  typedef struct {
    bit         stb;
    logic [7:0] d;
    bit         rdy;
    bit         clr;
    int         e_count;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_full;
    bit         e_ovr;
    int         e_ocnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock with the given inputs; scoreboard pops on fire, pushes on accepted write.
  task automatic cycle(input bit stb, input logic [7:0] d, input bit rdy, input bit clr);
    bit fire;
    wr_stb = stb; wr_data = d; rd_ready = rdy; ovr_clr = clr;
    #1;
    check("rd_valid_pre", int'(rd_valid), int'(sb_q.size() > 0));
    fire = rdy && (sb_q.size() > 0);
    if (fire) begin
      check("rd_data", int'(rd_data), int'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (stb) begin
      if (sb_q.size() < DEPTH) begin
        sb_q.push_back(d);
      end else begin
        m_ovr  = 1'b1;
        m_ocnt = clr ? 1 : ((m_ocnt == 255) ? 255 : m_ocnt + 1);
      end
    end else if (clr) begin
      m_ovr  = 1'b0;
      m_ocnt = 0;
    end else if (clr) begin
      m_ovr = 1'b0;
    end
    if (stb && clr && sb_q.size() < DEPTH && !m_ovr) begin
      m_ocnt = 0;
    end
    @(posedge clk);
    #1;
    wr_stb = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;
    check("count", int'(count), sb_q.size());
    check("full", int'(full), int'(sb_q.size() == DEPTH));
    check("overrun", int'(overrun), int'(m_ovr));
    check("ovr_cnt", int'(ovr_cnt), m_ocnt);
  endtask

  task automatic do_reset(input bit stb);
    rst = 1'b1; wr_stb = stb; wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_stb = 1'b0;
    sb_q.delete();
    m_ovr = 1'b0;
    m_ocnt = 0;
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(rd_valid), 0);
    check("rst_full", int'(full), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_ovr_cnt", int'(ovr_cnt), 0);
  endtask

  initial begin
    vecs[0] = '{1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0, 0};
    vecs[1] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[2] = '{1, 8'h3C, 0, 0, 1, 1, 8'h3C, 0, 0, 0};
    vecs[3] = '{1, 8'hC3, 1, 0, 1, 1, 8'hC3, 0, 0, 0};
    vecs[4] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[5] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[6] = '{1, 8'h5A, 1, 0, 1, 1, 8'h5A, 0, 0, 0};
    vecs[7] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Single byte, simultaneous read/write, read while empty, write+read while empty
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].stb, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      check("vec_count", int'(count), vecs[i].e_count);
      check("vec_valid", int'(rd_valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) check("vec_data", int'(rd_data), int'(vecs[i].e_data));
      check("vec_full", int'(full), int'(vecs[i].e_full));
      check("vec_ovr", int'(overrun), int'(vecs[i].e_ovr));
      check("vec_ocnt", int'(ovr_cnt), vecs[i].e_ocnt);
    end

    // Fill to full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);

    // Three drops, then clear
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_cnt3", int'(ovr_cnt), 3);
    check("ovr_head", int'(rd_data), 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovr", int'(overrun), 0);
    check("clr_cnt", int'(ovr_cnt), 0);

    // Full with simultaneous read and write
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("frw_count", int'(count), 16);
    check("frw_ovr", int'(overrun), 0);
    check("frw_head", int'(rd_data), 8'h01);

    // Drain; scoreboard expects 0x01..0x0F then 0x77
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_valid", int'(rd_valid), 0);
    check("drain_count", int'(count), 0);

    // Wrap-around: 40 writes, occupancy held at 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 3; i < 40; i++) begin
      cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      if (count < 1 || count > 5) check("wrap_range", int'(count), 3);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_empty", int'(rd_valid), 0);

    // Saturation of ovr_cnt, then drop wins over clear
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 258; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("sat_cnt", int'(ovr_cnt), 255);
    cycle(1'b1, 8'hAB, 1'b0, 1'b1);
    check("drop_wins_ovr", int'(overrun), 1);
    check("drop_wins_cnt", int'(ovr_cnt), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation with a strobe in the reset cycle
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("pre_rst_count", int'(count), 8);
    do_reset(1'b1);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    check("post_rst_data", int'(rd_data), 8'h99);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_ERR_EN
    wr_err = 1'b1;
    cycle(1'b1, 8'hE7, 1'b0, 1'b0);
    wr_err = 1'b0;
    check("rd_err", int'(rd_err), 1);
    check("err_seen", int'(err_seen), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("err_clr", int'(err_seen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
